// File: rtl/shared_alu_pkg.sv
// rtl/shared_alu_pkg.sv - opcodes, scheduler states and widths for the shared ALU scheduler
package shared_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_LT  = 4'd8,
        OP_EQ  = 4'd9,
        OP_GT  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/shared_alu_sched_if.sv
// rtl/shared_alu_sched_if.sv - requester/response bundle between requesters and the scheduler
interface shared_alu_sched_if
    import shared_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [OP_W*NREQ-1:0]  req_op;
    logic [WIDTH*NREQ-1:0] req_left;
    logic [WIDTH*NREQ-1:0] req_right;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;
    logic                  busy;

    modport master (
        output req_valid, req_op, req_left, req_right, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  req_valid, req_op, req_left, req_right, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/alu_prims.sv
// rtl/alu_prims.sv - combinational ALU primitives shared across the codebase
module Add #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a + b;
endmodule

module Sub #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a - b;
endmodule

module MultComb #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a * b;
endmodule

module And #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a & b;
endmodule

module Or #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a | b;
endmodule

module Xor #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a ^ b;
endmodule

// Shift amount is the whole operand; anything >= W clears the result.
module ShiftLeft #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = (b > W'(W - 1)) ? '0 : (a << b);
endmodule

module ShiftRight #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = (b > W'(W - 1)) ? '0 : (a >> b);
endmodule

module Lt #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         y
);
    assign y = (a < b);
endmodule

module Eq #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         y
);
    assign y = (a == b);
endmodule

module Gt #(parameter int W = 32) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         y
);
    assign y = (a > b);
endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or above ptr
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);
    always_comb begin
        logic found;
        int   j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end
endmodule

// File: rtl/shared_alu_sched.sv
// rtl/shared_alu_sched.sv - round-robin scheduler feeding one shared ALU, one op in flight
module shared_alu_sched
    import shared_alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NREQ       = 4,
    parameter int MUL_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    shared_alu_sched_if.slave bus
);
    localparam int IW    = $clog2(NREQ);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    sched_state_e     state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    idx_q;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_err_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic [OP_W-1:0]  sel_op;

    rr_arbiter #(.N(NREQ), .PW(IW)) u_arb (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign sel_op         = bus.req_op[OP_W*arb_idx +: OP_W];
    assign bus.req_ready  = (state == IDLE) ? arb_gnt : '0;
    assign bus.resp_valid = (state == RESP) ? (NREQ'(1) << idx_q) : '0;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.busy       = (state != IDLE);

    logic [WIDTH-1:0] add_y, sub_y, mul_y, and_y, or_y, xor_y, shl_y, shr_y;
    logic             lt_y, eq_y, gt_y;

    Add        #(.W(WIDTH)) u_add (.a(left_q), .b(right_q), .y(add_y));
    Sub        #(.W(WIDTH)) u_sub (.a(left_q), .b(right_q), .y(sub_y));
    MultComb   #(.W(WIDTH)) u_mul (.a(left_q), .b(right_q), .y(mul_y));
    And        #(.W(WIDTH)) u_and (.a(left_q), .b(right_q), .y(and_y));
    Or         #(.W(WIDTH)) u_or  (.a(left_q), .b(right_q), .y(or_y));
    Xor        #(.W(WIDTH)) u_xor (.a(left_q), .b(right_q), .y(xor_y));
    ShiftLeft  #(.W(WIDTH)) u_shl (.a(left_q), .b(right_q), .y(shl_y));
    ShiftRight #(.W(WIDTH)) u_shr (.a(left_q), .b(right_q), .y(shr_y));
    Lt         #(.W(WIDTH)) u_lt  (.a(left_q), .b(right_q), .y(lt_y));
    Eq         #(.W(WIDTH)) u_eq  (.a(left_q), .b(right_q), .y(eq_y));
    Gt         #(.W(WIDTH)) u_gt  (.a(left_q), .b(right_q), .y(gt_y));

    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    always_comb begin
        alu_y   = '0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD:  alu_y = add_y;
            OP_SUB:  alu_y = sub_y;
            OP_MUL:  alu_y = mul_y;
            OP_AND:  alu_y = and_y;
            OP_OR:   alu_y = or_y;
            OP_XOR:  alu_y = xor_y;
            OP_SHL:  alu_y = shl_y;
            OP_SHR:  alu_y = shr_y;
            OP_LT:   alu_y = {{(WIDTH-1){1'b0}}, lt_y};
            OP_EQ:   alu_y = {{(WIDTH-1){1'b0}}, eq_y};
            OP_GT:   alu_y = {{(WIDTH-1){1'b0}}, gt_y};
            default: alu_err = 1'b1;
        endcase
    end

    // The multiplier output is only sampled after MUL_CYCLES EXEC cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            left_q      <= '0;
            right_q     <= '0;
            cnt         <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        idx_q   <= arb_idx;
                        op_q    <= sel_op;
                        left_q  <= bus.req_left[WIDTH*arb_idx +: WIDTH];
                        right_q <= bus.req_right[WIDTH*arb_idx +: WIDTH];
                        rr_ptr  <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                        cnt     <= (sel_op == OP_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_data_q <= alu_y;
                        resp_err_q  <= alu_err;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready[idx_q]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_alu_sched.sv
// tb/tb_shared_alu_sched.sv - randomized and directed bench with a behavioural scheduler/ALU model
module tb_shared_alu_sched;
    localparam int WIDTH      = 32;
    localparam int NREQ       = 4;
    localparam int MUL_CYCLES = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    shared_alu_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    shared_alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0]  p_valid;
    logic [3:0]  p_op [4];
    logic [31:0] p_l  [4];
    logic [31:0] p_r  [4];
    int          mptr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result: {err, data}
    function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        case (op)
            4'd0: return {1'b0, a + b};
            4'd1: return {1'b0, a - b};
            4'd2: begin prod = 64'(a) * 64'(b); return {1'b0, prod[31:0]}; end
            4'd3: return {1'b0, a & b};
            4'd4: return {1'b0, a | b};
            4'd5: return {1'b0, a ^ b};
            4'd6: return (b >= 32) ? 33'd0 : {1'b0, a << b};
            4'd7: return (b >= 32) ? 33'd0 : {1'b0, a >> b};
            4'd8: return (a < b)  ? 33'd1 : 33'd0;
            4'd9: return (a == b) ? 33'd1 : 33'd0;
            4'd10: return (a > b) ? 33'd1 : 33'd0;
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic drive();
        bus.req_valid = p_valid;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_op[4*i +: 4]     = p_op[i];
            bus.req_left[32*i +: 32] = p_l[i];
            bus.req_right[32*i +: 32] = p_r[i];
        end
    endtask

    task automatic put(input int i, input logic [3:0] op, input logic [31:0] l, input logic [31:0] r);
        p_valid[i] = 1'b1;
        p_op[i]    = op;
        p_l[i]     = l;
        p_r[i]     = r;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        p_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_op[i] = '0; p_l[i] = '0; p_r[i] = '0;
        end
        bus.resp_ready = '0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_err", bus.resp_err, 0);
        reset_n = 1'b1;
        mptr = 0;
    endtask

    // Expects pending requests already driven, called between a posedge and the next.
    task automatic serve(input int hold, output int w);
        logic [32:0] expv;
        logic [3:0]  oh;
        int lat;
        int explat;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (mptr + k) % NREQ;
            if (w < 0 && p_valid[j]) w = j;
        end
        if (w < 0) return;
        oh = 4'b0001 << w;
        chk("grant", bus.req_ready, oh);
        expv   = ref_alu(p_op[w], p_l[w], p_r[w]);
        explat = (p_op[w] == 4'd2) ? 1 + MUL_CYCLES : 2;
        @(posedge clk);
        #1;
        p_valid[w] = 1'b0;
        drive();
        mptr = (w + 1) % NREQ;
        lat = 0;
        while (bus.resp_valid == '0 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid == '0) chk("exec_no_grant", bus.req_ready, 0);
        end
        chk("latency", lat, explat);
        chk("resp_valid", bus.resp_valid, oh);
        chk("resp_data", bus.resp_data, expv[31:0]);
        chk("resp_err", bus.resp_err, expv[32]);
        for (int h = 0; h < hold; h++) begin
            bus.resp_ready = 4'($urandom) & ~oh;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", bus.resp_valid, oh);
            chk("hold_data", bus.resp_data, expv[31:0]);
            chk("hold_err", bus.resp_err, expv[32]);
            chk("hold_no_grant", bus.req_ready, 0);
        end
        bus.resp_ready = oh | 4'($urandom);
        @(posedge clk);
        #1;
        bus.resp_ready = '0;
        @(negedge clk);
        chk("done_busy", bus.busy, 0);
        chk("done_resp_valid", bus.resp_valid, 0);
    endtask

    initial begin
        int w;
        int order [5];
        order = '{0, 1, 2, 3, 0};

        do_reset();

        put(0, 4'd0, 32'd7, 32'd5); drive(); #1; serve(0, w);
        put(2, 4'd2, 32'hFFFF_FFFF, 32'd2); drive(); #1; serve(0, w);

        // Backpressure with a competitor waiting.
        put(0, 4'd5, 32'hA5A5_0F0F, 32'h0FF0_1234);
        put(1, 4'd0, 32'd100, 32'd23);
        drive(); #1; serve(10, w);
        drive(); #1; serve(0, w);

        put(3, 4'd7, 32'h8000_0000, 32'd32); drive(); #1; serve(0, w);
        put(1, 4'd1, 32'd0, 32'd1);          drive(); #1; serve(0, w);
        put(0, 4'd8, 32'd3, 32'd9);          drive(); #1; serve(0, w);
        put(2, 4'd13, 32'd55, 32'd66);       drive(); #1; serve(1, w);
        put(1, 4'd6, 32'h0000_0001, 32'd31); drive(); #1; serve(0, w);

        // Round-robin with all requesters kept busy.
        do_reset();
        for (int i = 0; i < NREQ; i++) put(i, 4'd0, 32'(i * 10), 32'(i));
        for (int t = 0; t < 5; t++) begin
            drive(); #1; serve(0, w);
            chk("rr_order", w, order[t]);
            put(w, 4'($urandom_range(0, 10)), $urandom, 32'($urandom_range(0, 40)));
        end

        // Async reset in the second EXEC cycle of a MUL.
        do_reset();
        put(1, 4'd2, 32'd12345, 32'd678); drive(); #1;
        chk("mul_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        p_valid[1] = 1'b0; drive();
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_resp_valid", bus.resp_valid, 0);
        chk("arst_req_ready", bus.req_ready, 0);
        chk("arst_resp_data", bus.resp_data, 0);
        chk("arst_resp_err", bus.resp_err, 0);
        @(negedge clk);
        reset_n = 1'b1;
        mptr = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("arst_no_stale", bus.resp_valid, 0);
        end
        put(3, 4'd0, 32'd1, 32'd2);
        put(0, 4'd4, 32'hF0, 32'h0F);
        drive(); #1; serve(0, w);
        chk("arst_first_grant", w, 0);
        drive(); #1; serve(0, w);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!p_valid[i] && $urandom_range(0, 1) == 1) begin
                    put(i, 4'($urandom_range(0, 15)), $urandom,
                        ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom);
                end
            end
            if (p_valid == '0) put($urandom_range(0, 3), 4'($urandom_range(0, 15)), $urandom, $urandom);
            drive(); #1;
            serve($urandom_range(0, 3), w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
